// File: rtl/uart_rx_core_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// master = downstream consumer that pops bytes; slave = the receiver core.
interface uart_rx_core_if;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   modport master (
      output rd_en, clr_err,
      input  rd_data, rd_valid, busy, frame_err, overrun, parity_err
   );

   modport slave (
      input  rd_en, clr_err,
      output rd_data, rd_valid, busy, frame_err, overrun, parity_err
   );
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver (8N1) feeding a small FWFT FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module uart_rx_core #(
   parameter int CLK_DIV    = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_i,
   uart_rx_core_if.slave bus
);
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q;
   logic [TW-1:0] tick_q;
   logic [3:0]    samp_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          s7_q, s8_q;
   logic          push_q;
   logic          frame_err_q;
   logic          overrun_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, rptr_q, wptr_d, rptr_d;
   logic          tick, vote, at_vote, at_end;
   logic          empty, full, pop, wr;

   assign tick    = (tick_q == TW'(CLK_DIV - 1));
   assign vote    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
   assign at_vote = tick && (samp_q == 4'd9);
   assign at_end  = tick && (samp_q == 4'd15);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, parity_err_q;
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         samp_q      <= '0;
         bit_q       <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         // Clears first so a same-cycle set below takes priority.
         if (bus.clr_err) begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
         end
         if (state_q == IDLE) begin
            tick_q <= '0;
            samp_q <= '0;
            bit_q  <= '0;
         end else begin
            tick_q <= tick ? '0 : tick_q + 1'b1;
            if (tick) begin
               samp_q <= samp_q + 4'd1;
               if (samp_q == 4'd7) s7_q <= rx_s_q;
               if (samp_q == 4'd8) s8_q <= rx_s_q;
            end
         end
         case (state_q)
            IDLE: begin
`ifdef UART_RX_PARITY_EN
               par_bad_q <= 1'b0;
`endif
               if (!rx_s_q) state_q <= START;
            end
            START: begin
               if (at_vote && vote) state_q <= IDLE;
               else if (at_end)     state_q <= DATA;
            end
            DATA: begin
               if (at_vote) shift_q <= {vote, shift_q[7:1]};
               if (at_end) begin
                  bit_q <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_q == 3'd7) state_q <= PARITY;
`else
                  if (bit_q == 3'd7) state_q <= STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_vote) begin
                  par_bad_q <= vote ^ (^shift_q);
                  if (vote ^ (^shift_q)) parity_err_q <= 1'b1;
               end
               if (at_end) state_q <= STOP;
            end
`endif
            STOP: begin
               // Re-arm at mid-stop so a following start bit is not missed.
               if (at_vote) begin
                  if (vote) begin
`ifdef UART_RX_PARITY_EN
                     push_q <= !par_bad_q;
`else
                     push_q <= 1'b1;
`endif
                     state_q <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop    = bus.rd_en && !empty;
   assign wr     = push_q && (!full || pop);
   assign wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
   assign rptr_d = pop ? rptr_q + 1'b1 : rptr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (bus.clr_err) overrun_q <= 1'b0;
         if (push_q && full && !pop) overrun_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q[AW-1:0]] <= shift_q;
   end

   assign bus.rd_data   = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
   assign bus.rd_valid  = !empty;
   assign bus.busy      = (state_q != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLK_DIV=5 (80 clk per bit), FIFO_DEPTH=4.
module tb_uart_rx_core;
   localparam int BIT = 80;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   uart_rx_core_if bus();

   uart_rx_core #(.CLK_DIV(5), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_i  (rx_i),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_data(input logic [7:0] d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_data(d);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(1'b1);
   endtask

   task automatic pulse_rd();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.rd_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      checks++; if ({bus.frame_err, bus.overrun, bus.parity_err} !== 3'b000) begin errors++;
         $display("FAIL rst_flags: got %b want 000", {bus.frame_err, bus.overrun, bus.parity_err}); end
   endtask

   task automatic test_single_frame();
      send_data(8'hA5);
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t1_early: rd_valid %b before stop, want 0", bus.rd_valid); end
`ifdef UART_RX_PARITY_EN
      drive_bit(1'b0);
`endif
      rx_i = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t1_pre_vote: rd_valid %b want 0", bus.rd_valid); end
      repeat (40) @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h want a5", bus.rd_data); end
      checks++; if ({bus.frame_err, bus.overrun, bus.parity_err} !== 3'b000) begin errors++;
         $display("FAIL t1_flags: got %b want 000", {bus.frame_err, bus.overrun, bus.parity_err}); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", bus.busy); end
      pulse_rd();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t1_pop: rd_valid %b want 0", bus.rd_valid); end
      pulse_rd();
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL t1_empty_pop: rd_data %h want 00", bus.rd_data); end
   endtask

   task automatic test_glitch();
      rx_i = 1'b0;
      repeat (3) @(negedge clk);
      rx_i = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t2_start_seen: busy %b want 1", bus.busy); end
      repeat (80) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t2_rejected: busy %b want 0", bus.busy); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t2_no_push: rd_valid %b want 0", bus.rd_valid); end
   endtask

   task automatic test_frame_err();
      send_data(8'h3C);
      rx_i = 1'b0;
      repeat (200) @(negedge clk);
      checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL t3_ferr: got %b want 1", bus.frame_err); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t3_busy_low: got %b want 1", bus.busy); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t3_no_byte: rd_valid %b want 0", bus.rd_valid); end
      rx_i = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t3_busy_high: got %b want 0", bus.busy); end
      checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL t3_sticky: got %b want 1", bus.frame_err); end
      pulse_clr();
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL t3_clr: got %b want 0", bus.frame_err); end
      repeat (BIT) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      for (int i = 1; i <= 5; i++) send_frame(8'(i));
      repeat (20) @(negedge clk);
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL t4_overrun: got %b want 1", bus.overrun); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL t4_ferr: got %b want 0", bus.frame_err); end
      pulse_clr();
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL t4_clr: got %b want 0", bus.overrun); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL t4_fifo_kept: rd_valid %b want 1", bus.rd_valid); end
      for (int i = 1; i <= 4; i++) begin
         exp = 8'(i);
         checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL t4_pop%0d: got %h want %h", i, bus.rd_data, exp); end
         pulse_rd();
      end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t4_drained: rd_valid %b want 0", bus.rd_valid); end
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h11);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1 & 8'h77 >> i);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t5_busy_pre: got %b want 1", bus.busy); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL t5_valid_pre: got %b want 1", bus.rd_valid); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rx_i  = 1'b1;
      test_reset();
      repeat (2 * BIT) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_idle: busy %b want 0", bus.busy); end
      send_frame(8'h5A);
      repeat (5) @(negedge clk);
      checks++; if (bus.rd_data !== 8'h5A) begin errors++; $display("FAIL t5_data: got %h want 5a", bus.rd_data); end
      checks++; if ({bus.frame_err, bus.overrun, bus.parity_err} !== 3'b000) begin errors++;
         $display("FAIL t5_flags: got %b want 000", {bus.frame_err, bus.overrun, bus.parity_err}); end
      pulse_rd();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t5_single: rd_valid %b want 0", bus.rd_valid); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      send_data(8'h07);
      drive_bit(1'b0);
      drive_bit(1'b1);
      checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL t6_perr: got %b want 1", bus.parity_err); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL t6_discard: rd_valid %b want 0", bus.rd_valid); end
      pulse_clr();
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL t6_clr: got %b want 0", bus.parity_err); end
      send_data(8'h07);
      drive_bit(1'b1);
      drive_bit(1'b1);
      checks++; if (bus.rd_data !== 8'h07) begin errors++; $display("FAIL t6_data: got %h want 07", bus.rd_data); end
      checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL t6_ok: parity_err %b want 0", bus.parity_err); end
      pulse_rd();
   endtask
`endif

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      test_single_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
